// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - two-stage issue/writeback sequencer around a 16-bit 74181-style ALU slice
module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic [2:0]  in_rd,
    output logic [3:0]  alu_s,
    output logic        alu_m,
    output logic        alu_ci,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic        alu_co,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [2:0]  out_rd,
    output logic        out_wr,
    output logic        out_illegal,
    output logic [3:0]  out_flags,
    output logic [3:0]  flags
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_ADC   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOTA  = 4'd7;
    localparam logic [3:0] OP_CMP   = 4'd8;
    localparam logic [3:0] OP_INC   = 4'd9;
    localparam logic [3:0] OP_DEC   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;

    // execute stage registers
    logic        e_valid;
    logic [3:0]  e_op;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [2:0]  e_rd;

    // architectural {N,Z,C,V}; C sits at bit 1
    logic [3:0]  flag_q;

    logic        e_adv;
    logic        e_to_w;
    logic        reserved;
    logic [3:0]  new_flags;

    assign e_adv    = !out_valid || out_ready;
    assign in_ready = !e_valid || e_adv;
    assign e_to_w   = e_valid && e_adv;
    assign reserved = e_op[3] && e_op[2];

    assign alu_a = e_a;
    assign alu_b = e_b;
    assign flags = flag_q;

    // opcode decode to ALU controls; an empty E stage drives all zeros
    always_comb begin
        alu_s  = 4'b0000;
        alu_m  = 1'b0;
        alu_ci = 1'b0;
        if (e_valid) begin
            case (e_op)
                OP_ADD:         alu_s = 4'b1001;
                OP_ADC:         begin alu_s = 4'b1001; alu_ci = flag_q[1]; end
                OP_SUB, OP_CMP: begin alu_s = 4'b0110; alu_ci = 1'b1; end
                OP_SBC:         begin alu_s = 4'b0110; alu_ci = flag_q[1]; end
                OP_AND:         begin alu_s = 4'b1011; alu_m = 1'b1; end
                OP_OR:          begin alu_s = 4'b1110; alu_m = 1'b1; end
                OP_XOR:         begin alu_s = 4'b0110; alu_m = 1'b1; end
                OP_NOTA:        begin alu_s = 4'b0000; alu_m = 1'b1; end
                OP_INC:         begin alu_s = 4'b0000; alu_ci = 1'b1; end
                OP_DEC:         alu_s = 4'b1111;
                OP_PASSB:       begin alu_s = 4'b1010; alu_m = 1'b1; end
                default:        begin alu_s = 4'b0000; alu_m = 1'b1; end
            endcase
        end
    end

    // flags the op in E would commit; logic ops keep C, reserved ops keep everything
    always_comb begin
        new_flags = flag_q;
        if (!reserved) begin
            new_flags[3] = alu_y[15];
            new_flags[2] = (alu_y == 16'h0000);
            new_flags[0] = 1'b0;
            case (e_op)
                OP_ADD, OP_ADC: begin
                    new_flags[1] = alu_co;
                    new_flags[0] = (e_a[15] == e_b[15]) && (alu_y[15] != e_a[15]);
                end
                OP_INC: begin
                    new_flags[1] = alu_co;
                    new_flags[0] = !e_a[15] && alu_y[15];
                end
                OP_SUB, OP_SBC, OP_CMP: begin
                    new_flags[1] = alu_co;
                    new_flags[0] = (e_a[15] != e_b[15]) && (alu_y[15] != e_a[15]);
                end
                OP_DEC: begin
                    new_flags[1] = alu_co;
                    new_flags[0] = e_a[15] && !alu_y[15];
                end
                default: ;
            endcase
        end
    end

    // E stage: refills whenever it is empty or its occupant moves on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_op    <= 4'd0;
            e_a     <= 16'h0000;
            e_b     <= 16'h0000;
            e_rd    <= 3'd0;
        end else if (in_ready) begin
            e_valid <= in_valid;
            if (in_valid) begin
                e_op <= in_op;
                e_a  <= in_a;
                e_b  <= in_b;
                e_rd <= in_rd;
            end
        end
    end

    // W stage: captures result, tag and flag snapshot; holds while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= 16'h0000;
            out_rd      <= 3'd0;
            out_wr      <= 1'b0;
            out_illegal <= 1'b0;
            out_flags   <= 4'b0000;
        end else if (e_adv) begin
            out_valid <= e_valid;
            if (e_valid) begin
                out_result  <= reserved ? 16'h0000 : alu_y;
                out_rd      <= e_rd;
                out_wr      <= !reserved && (e_op != OP_CMP);
                out_illegal <= reserved;
                out_flags   <= new_flags;
            end
        end
    end

    // architectural flag register commits as the op leaves E
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 4'b0000;
        end else if (e_to_w && !reserved) begin
            flag_q <= new_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq against a behavioural model
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_rd;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_ci;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_y;
    logic        alu_co;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wr;
    logic        out_illegal;
    logic [3:0]  out_flags;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .alu_s(alu_s), .alu_m(alu_m), .alu_ci(alu_ci),
        .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y), .alu_co(alu_co),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wr(out_wr), .out_illegal(out_illegal),
        .out_flags(out_flags), .flags(flags)
    );

    // 16-bit 74181 slice, active-high data and carries
    logic [16:0] alu_sum;
    always_comb begin
        alu_sum = 17'h0;
        if (alu_m) begin
            case (alu_s)
                4'b0000: alu_sum = {1'b0, ~alu_a};
                4'b1011: alu_sum = {1'b0, alu_a & alu_b};
                4'b1110: alu_sum = {1'b0, alu_a | alu_b};
                4'b0110: alu_sum = {1'b0, alu_a ^ alu_b};
                4'b1010: alu_sum = {1'b0, alu_b};
                default: alu_sum = 17'h0;
            endcase
        end else begin
            case (alu_s)
                4'b1001: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_ci};
                4'b0110: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {16'h0, alu_ci};
                4'b0000: alu_sum = {1'b0, alu_a} + {16'h0, alu_ci};
                4'b1111: alu_sum = {1'b0, alu_a} + 17'h0FFFF + {16'h0, alu_ci};
                default: alu_sum = 17'h0;
            endcase
        end
    end
    assign alu_y  = alu_sum[15:0];
    assign alu_co = alu_sum[16] & ~alu_m;

    typedef struct {
        logic [15:0] result;
        logic [2:0]  rd;
        logic        wr;
        logic        illegal;
        logic [3:0]  snap;
        logic [3:0]  arch;
    } exp_t;

    exp_t       q[$];
    logic [3:0] m_flags   = 4'b0000;
    logic [3:0] last_arch = 4'b0000;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // architectural meaning of each opcode, in plain integer arithmetic
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] rd, input logic [3:0] f);
        exp_t e;
        int ua, ub, sa, sb, r, sr, cin, bor;
        bit c, v, logic_op;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = f[1]; v = 1'b0; logic_op = 1'b0; r = 0; sr = 0;
        e.rd = rd; e.wr = (op != 4'd8); e.illegal = 1'b0;
        case (op)
            4'd0, 4'd1: begin
                cin = (op == 4'd1) ? int'(f[1]) : 0;
                r = ua + ub + cin; sr = sa + sb + cin; c = (r > 65535);
            end
            4'd2, 4'd3, 4'd8: begin
                bor = (op == 4'd3 && !f[1]) ? 1 : 0;
                r = ua - ub - bor; sr = sa - sb - bor; c = (r >= 0);
            end
            4'd9:  begin r = ua + 1; sr = sa + 1; c = (r > 65535); end
            4'd10: begin r = ua - 1; sr = sa - 1; c = (r >= 0); end
            4'd4:  begin r = int'({16'h0, a & b}); logic_op = 1'b1; end
            4'd5:  begin r = int'({16'h0, a | b}); logic_op = 1'b1; end
            4'd6:  begin r = int'({16'h0, a ^ b}); logic_op = 1'b1; end
            4'd7:  begin r = int'({16'h0, ~a});    logic_op = 1'b1; end
            4'd11: begin r = int'({16'h0, b});     logic_op = 1'b1; end
            default: begin
                e.result = 16'h0; e.wr = 1'b0; e.illegal = 1'b1;
                e.snap = f; e.arch = f;
                return e;
            end
        endcase
        if (!logic_op) v = (sr > 32767) || (sr < -32768);
        e.result = r[15:0];
        e.snap   = {r[15], (r[15:0] == 16'h0), c, v};
        e.arch   = e.snap;
        return e;
    endfunction

    // scoreboard: W always holds the oldest outstanding op
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_flags   = 4'b0000;
            last_arch = 4'b0000;
        end else begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("w_unexpected", out_valid, 0);
                end else begin
                    check("out_result",  out_result,  q[0].result);
                    check("out_rd",      out_rd,      q[0].rd);
                    check("out_wr",      out_wr,      q[0].wr);
                    check("out_illegal", out_illegal, q[0].illegal);
                    check("out_flags",   out_flags,   q[0].snap);
                    check("flags_w",     flags,       q[0].arch);
                end
            end else begin
                check("flags_idle", flags, last_arch);
            end
            if (out_valid && out_ready && q.size() > 0) begin
                last_arch = q[0].arch;
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(in_op, in_a, in_b, in_rd, m_flags);
                m_flags = e.arch;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] rd);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [3:0] prev_flags;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 16'h0; in_b = 16'h0; in_rd = 3'd0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_flags", flags, 4'b0000);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_alu_s", alu_s, 4'b0000);
        check("rst_out_result", out_result, 16'h0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);

        // ADD 0x7FFF + 1: overflow into the sign bit, two-edge latency
        drive(4'd0, 16'h7FFF, 16'h0001, 3'd1);
        tick();
        in_valid = 1'b0;
        check("lat_edge_k", out_valid, 0);
        tick();
        check("lat_edge_k1", out_valid, 1);
        check("add_result", out_result, 16'h8000);
        check("add_flags", out_flags, 4'b1001);
        check("add_wr", out_wr, 1);

        // ADD then dependent ADC with no bubble
        drive(4'd0, 16'hFFFF, 16'h0001, 3'd2);
        tick();
        drive(4'd1, 16'h0000, 16'h0000, 3'd3);
        tick();
        in_valid = 1'b0;
        check("adc_ci", alu_ci, 1);
        check("chain_add_result", out_result, 16'h0000);
        check("chain_add_flags", out_flags, 4'b0110);
        tick();
        check("adc_result", out_result, 16'h0001);
        check("adc_c", out_flags[1], 0);

        // CMP equal operands
        drive(4'd8, 16'h1234, 16'h1234, 3'd4);
        tick();
        in_valid = 1'b0;
        tick();
        check("cmp_wr", out_wr, 0);
        check("cmp_flags", out_flags, 4'b0110);

        // stall with three ops streamed
        tick();
        out_ready = 1'b0;
        drive(4'd0, 16'h0001, 16'h0001, 3'd5);
        tick();
        check("stall_ready1", in_ready, 1);
        drive(4'd2, 16'h0005, 16'h0003, 3'd6);
        tick();
        drive(4'd6, 16'h00FF, 16'h0F0F, 3'd7);
        check("stall_ready2", in_ready, 0);
        repeat (3) tick();
        check("stall_ready3", in_ready, 0);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();

        // reserved opcode
        prev_flags = m_flags;
        drive(4'd13, 16'h1111, 16'h2222, 3'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("ill_illegal", out_illegal, 1);
        check("ill_wr", out_wr, 0);
        check("ill_result", out_result, 16'h0);
        check("ill_flags", flags, prev_flags);
        tick();

        // randomized traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 4'($urandom_range(0, 15));
            in_a      = pick();
            in_b      = pick();
            in_rd     = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);

        // reset with both stages full
        out_ready = 1'b0;
        drive(4'd0, 16'hFFFF, 16'h0001, 3'd2);
        tick();
        drive(4'd0, 16'h0002, 16'h0002, 3'd3);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_flags", flags, 4'b0110);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", out_valid, 0);
        check("rst_async_flags", flags, 4'b0000);
        check("rst_async_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_valid", out_valid, 0);
        tick();
        check("post_rst_valid2", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
